// File: rtl/cpu19_pkg.sv
// Shared types and constants for the return-stack link sequencer.
// Exports ADDR_W, STACK_DEPTH, DEPTH_W, addr_t, depth_t and the FSM state enum.
package cpu19_pkg;

    localparam int ADDR_W      = 19;
    localparam int STACK_DEPTH = 32;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DEPTH_W-1:0] depth_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_C_SETUP,
        ST_C_PULSE,
        ST_R_PULSE,
        ST_R_WAIT,
        ST_R_CAPT,
        ST_FL_PULSE
    } slc_state_e;

endpackage

// File: rtl/stack_link_ctrl_if.sv
// Control-unit side of the return-stack link: CALL/RET/flush requests in,
// ready / ret_addr / ret_valid / depth back. master = control unit, slave = sequencer.
interface stack_link_ctrl_if;
    import cpu19_pkg::*;

    logic   call_req;
    addr_t  call_addr;
    logic   ret_req;
    logic   flush;
    logic   ready;
    addr_t  ret_addr;
    logic   ret_valid;
    depth_t depth;

    modport master (
        output call_req, call_addr, ret_req, flush,
        input  ready, ret_addr, ret_valid, depth
    );

    modport slave (
        input  call_req, call_addr, ret_req, flush,
        output ready, ret_addr, ret_valid, depth
    );

endinterface

// File: rtl/stack_link_ctrl_depth.sv
// stack_depth_ctr: saturating entry counter (0..DEPTH) with full/empty flags.
// Ports: clk, rst_n, inc_i, dec_i, clr_i -> depth_o, full_o, empty_o.
module stack_depth_ctr #(
    parameter int DEPTH = 32,
    parameter int W     = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         clr_i,
    output logic [W-1:0] depth_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && cnt_q != W'(DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign depth_o = cnt_q;
    assign full_o  = (cnt_q == W'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/stack_link_ctrl.sv
// Sequencer between the control unit and the 19x32 return stack: turns CALL/RET
// into isolated, flop-driven PUSH/POP/CLR pulses and returns popped addresses.
// Ports: CLK, RST_N, cu (slave modport), stk_inpData/stk_PUSH/stk_POP/stk_CLR out,
// stk_opData in; ovf_err/unf_err only when STACK_LINK_GUARD_EN is defined.
module stack_link_ctrl
    import cpu19_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    stack_link_ctrl_if.slave  cu,
    output addr_t             stk_inpData,
    output logic              stk_PUSH,
    output logic              stk_POP,
    output logic              stk_CLR,
    input  addr_t             stk_opData
`ifdef STACK_LINK_GUARD_EN
    ,
    output logic              ovf_err,
    output logic              unf_err
`endif
);

    slc_state_e st_q;
    logic       ready_q;
    logic       rv_q;
    logic       push_q;
    logic       pop_q;
    logic       clr_q;
    addr_t      ra_q;
    addr_t      inp_q;
    depth_t     depth_w;
    logic       full_w;
    logic       empty_w;
    logic       pulse_now;

    // A pulse high this cycle forces a low gap before any CLR a flush requests.
    assign pulse_now = push_q | pop_q | clr_q;

`ifdef STACK_LINK_GUARD_EN
    logic ovf_q;
    logic unf_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`else
    logic unused_flags;
    assign unused_flags = full_w | empty_w;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q    <= ST_INIT;
            ready_q <= 1'b0;
            rv_q    <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            clr_q   <= 1'b0;
            ra_q    <= '0;
            inp_q   <= '0;
`ifdef STACK_LINK_GUARD_EN
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            pop_q  <= 1'b0;
            clr_q  <= 1'b0;
            rv_q   <= 1'b0;
            if (st_q == ST_INIT) begin
                // The stack has no reset pin: clear it once per reset release.
                if (!clr_q) begin
                    clr_q <= 1'b1;
                end else begin
                    ready_q <= 1'b1;
                    st_q    <= ST_IDLE;
                end
            end else if (cu.flush) begin
                ready_q <= 1'b0;
                st_q    <= ST_FL_PULSE;
                clr_q   <= !pulse_now;
`ifdef STACK_LINK_GUARD_EN
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
`endif
            end else begin
                unique case (st_q)
                    ST_IDLE: begin
                        // ready low in IDLE only after a refused request.
                        if (!ready_q) begin
                            ready_q <= 1'b1;
                        end else if (cu.call_req) begin
                            ready_q <= 1'b0;
`ifdef STACK_LINK_GUARD_EN
                            if (full_w) begin
                                ovf_q <= 1'b1;
                            end else begin
                                inp_q <= cu.call_addr;
                                st_q  <= ST_C_SETUP;
                            end
`else
                            inp_q <= cu.call_addr;
                            st_q  <= ST_C_SETUP;
`endif
                        end else if (cu.ret_req) begin
                            ready_q <= 1'b0;
`ifdef STACK_LINK_GUARD_EN
                            if (empty_w) begin
                                unf_q <= 1'b1;
                            end else begin
                                pop_q <= 1'b1;
                                st_q  <= ST_R_PULSE;
                            end
`else
                            pop_q <= 1'b1;
                            st_q  <= ST_R_PULSE;
`endif
                        end
                    end
                    ST_C_SETUP: begin
                        push_q <= 1'b1;
                        st_q   <= ST_C_PULSE;
                    end
                    ST_C_PULSE: begin
                        ready_q <= 1'b1;
                        st_q    <= ST_IDLE;
                    end
                    ST_R_PULSE: begin
                        st_q <= ST_R_WAIT;
                    end
                    ST_R_WAIT: begin
                        ra_q <= stk_opData;
                        rv_q <= 1'b1;
                        st_q <= ST_R_CAPT;
                    end
                    ST_R_CAPT: begin
                        ready_q <= 1'b1;
                        st_q    <= ST_IDLE;
                    end
                    ST_FL_PULSE: begin
                        if (!clr_q) begin
                            clr_q <= 1'b1;
                        end else begin
                            ready_q <= 1'b1;
                            st_q    <= ST_IDLE;
                        end
                    end
                    default: begin
                        st_q <= ST_INIT;
                    end
                endcase
            end
        end
    end

    // Depth follows the pulses actually sent to the stack.
    stack_depth_ctr #(
        .DEPTH (STACK_DEPTH)
    ) u_depth (
        .clk     (CLK),
        .rst_n   (RST_N),
        .inc_i   (push_q),
        .dec_i   (pop_q),
        .clr_i   (clr_q),
        .depth_o (depth_w),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

    assign cu.ready     = ready_q;
    assign cu.ret_addr  = ra_q;
    assign cu.ret_valid = rv_q;
    assign cu.depth     = depth_w;
    assign stk_inpData  = inp_q;
    assign stk_PUSH     = push_q;
    assign stk_POP      = pop_q;
    assign stk_CLR      = clr_q;

endmodule
